// File: rtl/ff_bank_shift_if.sv
// Handshake-free control/data bundle for the ff_bank_shift register bank.
// master drives controls and data, slave (the bank) drives state and flags.
interface ff_bank_shift_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic             ser_in;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic             ser_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output en, mode, D, ser_in,
    input  Q, Qn, ser_out, rise, fall, changed
  );

  modport slave (
    input  en, mode, D, ser_in,
    output Q, Qn, ser_out, rise, fall, changed
  );
endinterface

// File: rtl/ff_bank_shift.sv
// WIDTH-bit register bank: hold / parallel load / shift left / shift right,
// with registered complement, serial tap and single-cycle per-bit edge flags.
module ff_bank_shift #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'h0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  ff_bank_shift_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qn_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic             changed_r;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = q_r;
    case (mode_e'(bus.mode))
      MODE_HOLD: nxt = q_r;
      MODE_LOAD: nxt = bus.D;
      MODE_SHL:  nxt = {q_r[WIDTH-2:0], bus.ser_in};
      MODE_SHR:  nxt = {bus.ser_in, q_r[WIDTH-1:1]};
      default:   nxt = q_r;
    endcase
  end

  // Qn is its own flop so it never glitches relative to Q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r       <= RST_Q;
      qn_r      <= ~RST_Q;
      rise_r    <= '0;
      fall_r    <= '0;
      changed_r <= 1'b0;
    end else if (bus.en) begin
      q_r       <= nxt;
      qn_r      <= ~nxt;
      rise_r    <= nxt & ~q_r;
      fall_r    <= ~nxt & q_r;
      changed_r <= |(nxt ^ q_r);
    end else begin
      rise_r    <= '0;
      fall_r    <= '0;
      changed_r <= 1'b0;
    end
  end

  assign bus.Q       = q_r;
  assign bus.Qn      = qn_r;
  assign bus.rise    = rise_r;
  assign bus.fall    = fall_r;
  assign bus.changed = changed_r;
  assign bus.ser_out = MSB_FIRST ? q_r[WIDTH-1] : q_r[0];

  mode_known_a: assert property (@(posedge clk) disable iff (rst)
    bus.en |-> !$isunknown(bus.mode));

endmodule
